// File: rtl/seg_scan_pkg.sv
// Shared constants for the segment scan decoder: glyph table, special codes, frame state.
package seg_scan_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_6_ALT = 7'h03;
  localparam logic [6:0] GLYPH_7_ALT = 7'h58;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [3:0] BLANK_CODE   = 4'hF;
  localparam logic [3:0] INVALID_CODE = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    FILLING,
    STALE
  } state_e;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational active-low 7-segment glyph to BCD lookup with blank/invalid flags.
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       blank_o,
  output logic       invalid_o
);

  always_comb begin
    code_o    = INVALID_CODE;
    blank_o   = 1'b0;
    invalid_o = 1'b0;
    case (seg_i)
      GLYPH_0:                 code_o = 4'd0;
      GLYPH_1:                 code_o = 4'd1;
      GLYPH_2:                 code_o = 4'd2;
      GLYPH_3:                 code_o = 4'd3;
      GLYPH_4:                 code_o = 4'd4;
      GLYPH_5:                 code_o = 4'd5;
      GLYPH_6, GLYPH_6_ALT:    code_o = 4'd6;
      GLYPH_7, GLYPH_7_ALT:    code_o = 4'd7;
      GLYPH_8:                 code_o = 4'd8;
      GLYPH_9:                 code_o = 4'd9;
      GLYPH_BLANK: begin
        code_o  = BLANK_CODE;
        blank_o = 1'b1;
      end
      default:                 invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers four BCD digits from a multiplexed active-low 7-segment scan.
// Optional binary output port `number` when SEG_BIN_OUT_EN is defined.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  invalid,
  output logic        frame_valid,
  output logic        stale
`ifdef SEG_BIN_OUT_EN
  ,
  output logic [13:0] number
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q;
  logic [10:0] sample_q;
  logic [9:0]  cnt_q, cnt_d;
  logic [TW-1:0] idle_q;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  blank_q, blank_d, invalid_q, invalid_d;
  logic        frame_valid_q, stale_q;
  logic        selecting, same, capture, frame_done, timeout;
  logic [3:0]  dec_code;
  logic        dec_blank, dec_invalid;

  seg_glyph_decode u_decode (
    .seg_i     (seg),
    .code_o    (dec_code),
    .blank_o   (dec_blank),
    .invalid_o (dec_invalid)
  );

  // Counter saturates so a long dwell can never wrap around and capture twice.
  always_comb begin
    selecting = $onehot(~an);
    same      = ({an, seg} == sample_q);
    if (!selecting || !same)   cnt_d = '0;
    else if (cnt_q != '1)      cnt_d = cnt_q + 10'd1;
    else                       cnt_d = cnt_q;
    capture    = selecting && same && (cnt_q == 10'(STABLE_CYCLES - 2));
    mask_d     = mask_q | ~an;
    frame_done = capture && (mask_d == 4'hF);
    timeout    = !capture && (state_q != STALE) && (idle_q == TW'(TIMEOUT_CYCLES - 1));
    digits_d   = digits_q;
    blank_d    = blank_q;
    invalid_d  = invalid_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!an[k]) begin
        digits_d[4*k +: 4] = dec_code;
        blank_d[k]         = dec_blank;
        invalid_d[k]       = dec_invalid;
      end
    end
  end

`ifdef SEG_BIN_OUT_EN
  logic [13:0] number_q, number_d;
  always_comb begin
    number_d = 14'(digits_d[15:12]) * 14'd1000 + 14'(digits_d[11:8]) * 14'd100
             + 14'(digits_d[7:4]) * 14'd10 + 14'(digits_d[3:0]);
  end
  assign number = number_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sample_q      <= '1;
      cnt_q         <= '0;
      idle_q        <= '0;
      mask_q        <= '0;
      digits_q      <= '1;
      blank_q       <= '1;
      invalid_q     <= '0;
      frame_valid_q <= 1'b0;
      stale_q       <= 1'b0;
`ifdef SEG_BIN_OUT_EN
      number_q      <= '0;
`endif
    end else begin
      sample_q      <= {an, seg};
      cnt_q         <= cnt_d;
      frame_valid_q <= frame_done;
      if (capture) begin
        digits_q  <= digits_d;
        blank_q   <= blank_d;
        invalid_q <= invalid_d;
        idle_q    <= '0;
        if (frame_done) begin
          mask_q  <= '0;
          stale_q <= 1'b0;
          state_q <= IDLE;
`ifdef SEG_BIN_OUT_EN
          if ((blank_d | invalid_d) == 4'h0) number_q <= number_d;
`endif
        end else begin
          mask_q  <= mask_d;
          state_q <= FILLING;
        end
      end else if (timeout) begin
        stale_q <= 1'b1;
        mask_q  <= '0;
        idle_q  <= '0;
        state_q <= STALE;
      end else if (state_q != STALE) begin
        idle_q <= idle_q + TW'(1);
      end
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign invalid     = invalid_q;
  assign frame_valid = frame_valid_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: randomized scans against a dwell-level model.
module tb_seg_scan_decoder;

  localparam int unsigned S = 16;
  localparam int unsigned T = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank, invalid;
  logic        frame_valid, stale;
`ifdef SEG_BIN_OUT_EN
  logic [13:0] number;
`endif

  seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .blank       (blank),
    .invalid     (invalid),
    .frame_valid (frame_valid),
    .stale       (stale)
`ifdef SEG_BIN_OUT_EN
    ,
    .number      (number)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  b;
    logic [3:0]  i;
    logic [13:0] n;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [6:0]  glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [15:0] mdig;
  logic [3:0]  mblank, minv, mmask;
  logic [13:0] mnum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] model_decode(input logic [6:0] s);
    for (int v = 0; v < 10; v++) if (glyph[v] == s) return {2'b00, 4'(v)};
    if (s == 7'h03) return 6'd6;
    if (s == 7'h58) return 6'd7;
    if (s == 7'h7F) return {2'b10, 4'hF};
    return {2'b01, 4'hE};
  endfunction

  task automatic model_reset();
    mdig = 16'hFFFF; mblank = 4'hF; minv = 4'h0; mmask = 4'h0; mnum = 14'd0;
  endtask

  task automatic model_capture(input logic [3:0] a, input logic [6:0] s);
    logic [5:0] r;
    exp_t e;
    int k;
    r = model_decode(s);
    k = 0;
    for (int j = 0; j < 4; j++) if (!a[j]) k = j;
    mdig[4*k +: 4] = r[3:0];
    mblank[k] = r[5];
    minv[k]   = r[4];
    mmask[k]  = 1'b1;
    if (mmask == 4'hF) begin
      if ((mblank | minv) == 4'h0)
        mnum = 14'(int'(mdig[15:12]) * 1000 + int'(mdig[11:8]) * 100 + int'(mdig[7:4]) * 10 + int'(mdig[3:0]));
      e.d = mdig; e.b = mblank; e.i = minv; e.n = mnum;
      exp_q.push_back(e);
      mmask = 4'h0;
    end
  endtask

  // Called at a negedge; holds {a,s} for len sampling edges.
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int unsigned len);
    if ($onehot(~a) && len >= S) model_capture(a, s);
    an = a; seg = s;
    repeat (len) @(posedge clk);
    @(negedge clk);
    chk("digits", 32'(digits), 32'(mdig));
    chk("blank", 32'(blank), 32'(mblank));
    chk("invalid", 32'(invalid), 32'(minv));
  endtask

  task automatic scan4(input logic [6:0] g3, input logic [6:0] g2, input logic [6:0] g1,
                       input logic [6:0] g0, input int unsigned len);
    dwell(4'b1110, g0, len);
    dwell(4'b1101, g1, len);
    dwell(4'b1011, g2, len);
    dwell(4'b0111, g3, len);
  endtask

  task automatic check_reset_vals();
    chk("rst_digits", 32'(digits), 32'hFFFF);
    chk("rst_blank", 32'(blank), 32'hF);
    chk("rst_invalid", 32'(invalid), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
`ifdef SEG_BIN_OUT_EN
    chk("rst_number", 32'(number), 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [6:0] rand_glyph();
    int unsigned p;
    p = $urandom_range(0, 19);
    if (p < 14) return glyph[$urandom_range(0, 9)];
    if (p == 14) return 7'h03;
    if (p == 15) return 7'h58;
    if (p == 16) return 7'h7F;
    return 7'($urandom_range(0, 127));
  endfunction

  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_valid", 32'(frame_valid), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_digits", 32'(digits), 32'(e.d));
        chk("frame_blank", 32'(blank), 32'(e.b));
        chk("frame_invalid", 32'(invalid), 32'(e.i));
        chk("frame_stale", 32'(stale), 32'h0);
`ifdef SEG_BIN_OUT_EN
        chk("frame_number", 32'(number), 32'(e.n));
`endif
      end
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; an = 4'hF; seg = 7'h7F;
    model_reset();
    @(negedge clk);
    do_reset();

    // Directed frame 4321
    scan4(glyph[4], glyph[3], glyph[2], glyph[1], 20);
    chk("dir_4321_digits", 32'(digits), 32'h4321);
    chk("dir_4321_flags", 32'({blank, invalid}), 32'h00);

    // One cycle short of the required dwell on every digit
    scan4(glyph[8], glyph[7], glyph[6], glyph[5], S - 1);
    chk("short_dwell_digits", 32'(digits), 32'h4321);

    // Blank and non-glyph patterns
    do_reset();
    scan4(7'h7F, 7'h55, glyph[0], glyph[9], 18);
    chk("dir_blank", 32'(blank), 32'b1000);
    chk("dir_invalid", 32'(invalid), 32'b0100);
    chk("dir_upper", 32'(digits[15:8]), 32'hFE);

    // Randomized scans with occasional gaps and short dwells
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 7) == 0)
          dwell(($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1111, 7'h7F, $urandom_range(1, 30));
        dwell(~(4'b0001 << k), rand_glyph(), $urandom_range(S - 2, S + 8));
      end
    end

    // Timeout after three digits, then recovery
    do_reset();
    dwell(4'b1110, glyph[7], 20);
    dwell(4'b1101, glyph[8], 20);
    dwell(4'b1011, glyph[9], 20);
    dwell(4'b1111, 7'h7F, T - 30);
    chk("stale_before_timeout", 32'(stale), 32'h0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    mmask = 4'h0;
    chk("stale_after_timeout", 32'(stale), 32'h1);
    chk("timeout_holds_digits", 32'(digits[11:0]), 32'h987);
    scan4(glyph[1], glyph[2], glyph[3], glyph[4], 20);
    chk("stale_cleared", 32'(stale), 32'h0);
    chk("post_stale_digits", 32'(digits), 32'h1234);

    // Multi-low anode held, then reset mid-frame
    dwell(4'b1110, glyph[5], 20);
    dwell(4'b1101, glyph[6], 20);
    dwell(4'b0011, glyph[2], 100);
    do_reset();

    // Reset in the middle of a dwell: the dwell must restart
    an = 4'b1110; seg = glyph[3];
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_vals();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_dwell_no_capture", 32'(digits), 32'hFFFF);
    dwell(4'b1101, glyph[2], 20);
    dwell(4'b1011, glyph[1], 20);
    dwell(4'b0111, glyph[0], 20);
    dwell(4'b1110, glyph[9], 20);
    chk("post_reset_frame", 32'(digits), 32'h0129);

`ifdef SEG_BIN_OUT_EN
    do_reset();
    scan4(glyph[9], glyph[9], glyph[9], glyph[9], 20);
    chk("number_9999", 32'(number), 32'd9999);
    scan4(glyph[1], glyph[2], 7'h7F, glyph[4], 20);
    chk("number_held", 32'(number), 32'd9999);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, meaning consecutive identical {an,seg} samples required before a digit is captured (legal range 2..1023).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 400000, meaning idle cycles without any capture before partial-frame state is discarded.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port seg  input  7  multiplexed segment lines, active-low, seg[0]=a … seg[6]=g.
REQ-006 SHALL have port an  input  4  multiplexed anode lines, active-low, an[0]=rightmost digit.
REQ-007 SHALL have port digits  output  16  captured BCD digits, digits[4k+3:4k] belongs to an[k].
REQ-008 SHALL have port blank  output  4  per-digit flag: captured pattern was all segments off.
REQ-009 SHALL have port invalid  output  4  per-digit flag: captured pattern was not a decimal glyph and not blank.
REQ-010 SHALL have port frame_valid  output  1  one-cycle pulse: all four digits captured since the previous frame.
REQ-011 SHALL have port stale  output  1  level: timeout expired since last frame_valid.

Function
REQ-012 SHALL treat an as "selecting" only when exactly one bit is 0; 4'b1111 and multi-low values reset the stability counter and never capture.
REQ-013 SHALL increment an 10-bit stability counter each cycle {an,seg} equals its previous-cycle value, and reset it to 0 on any change.
REQ-014 SHALL capture exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES-1; no further capture until {an,seg} changes.
REQ-015 SHALL decode per the package glyph table: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; 6 and 7 also accept 7'h03/7'h58 (alternate tails).
REQ-016 SHALL store 4'hF with blank=1 for 7'h7F, 4'hE with invalid=1 for any other non-table pattern; decimal decode clears both flags for that digit.
REQ-017 SHALL update digits/blank/invalid registers one cycle after the capture cycle (latency 1 from qualifying sample).
REQ-018 SHALL keep a 4-bit captured mask; recapture of an already-set position overwrites that digit without affecting the mask.
REQ-019 SHALL pulse frame_valid in the cycle the mask becomes 4'b1111, clear the mask in that same cycle, and clear stale.
REQ-020 SHALL use states IDLE (mask 0), FILLING (mask nonzero), STALE; IDLE->FILLING on capture, FILLING->IDLE on frame_valid, any->STALE on timeout, STALE->FILLING on capture.
REQ-021 SHALL count cycles since last capture; at TIMEOUT_CYCLES assert stale, clear mask, hold digits unchanged.
REQ-022 SHALL, when a capture and timeout coincide, give capture priority (counter reset, no stale).

Reset
REQ-023 SHALL, while rst is high at a clk edge, set digits=16'hFFFF, blank=4'hF, invalid=0, frame_valid=0, stale=0, mask=0, counters=0, state IDLE.
REQ-024 SHALL, on rst asserted mid-dwell or mid-frame, discard partial state; first capture after reset requires a full STABLE_CYCLES dwell.

Configuration
REQ-025 SHALL, with SEG_BIN_OUT_EN defined, add output number (14 bits) = d3*1000+d2*100+d1*10+d0, registered, updated with frame_valid, and only if no digit is blank/invalid (else held); reset value 0.
REQ-026 SHALL, without SEG_BIN_OUT_EN, omit port number and all conversion logic.

Structure
REQ-027 SHALL place glyph constants, BLANK_CODE/INVALID_CODE (4'hF/4'hE) and the state enum in package seg_scan_pkg.
REQ-028 SHALL implement glyph-to-BCD lookup in sub-module seg_glyph_decode (combinational, 7-bit in, 4-bit code + blank + invalid out); the remainder stays in seg_scan_decoder.

Verification
REQ-029 SHALL cover: scan an=1110/1101/1011/0111 with glyphs 1,2,3,4, 20-cycle dwells -> frame_valid once, digits=16'h4321, blank=0, invalid=0.
REQ-030 SHALL cover: dwell of 15 cycles (STABLE_CYCLES=16) on every digit -> no capture, no frame_valid.
REQ-031 SHALL cover: an[3] showing 7'h7F, an[2] showing 7'h55 -> blank=4'b1000, invalid=4'b0100, digits[15:8]=8'hFE.
REQ-032 SHALL cover: three digits captured then 400000 idle cycles -> stale=1, mask cleared, next full scan gives frame_valid and stale=0.
REQ-033 SHALL cover: an=4'b0011 held 100 cycles and rst asserted mid-frame -> no capture; post-reset outputs equal REQ-023 values.
REQ-034 SHALL cover (SEG_BIN_OUT_EN): scan 9,9,9,9 -> number=9999; then scan with one blank -> number stays 9999.
